macish_mac_p: RTL
=================

# macish_mac_p

Parametrised successor to the 8-bit macish approximate multiply-accumulate unit. It is an unsigned, two-stage pipelined MAC with configurable operand width, accumulator guard bits and truncation depth. A per-sample mode selects exact or approximate products, and a sticky overflow flag reports accumulator overflow. It sits in the datapath wherever the fixed macish MAC is used today and serves as the characterisation target for the error-analysis benches.

## Interface
- DATA_W, 8: operand width, unsigned.
- GUARD_W, 4: accumulator guard bits; ACC_W = 2*DATA_W + GUARD_W.
- APPROX_K, 4: low product bits truncated in approximate mode, 0..2*DATA_W-1.
- clk  in  1  clock, rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- clken  in  1  global clock enable; low freezes every register.
- in_valid  in  1  dataa/datab/sload/approx carry a sample this cycle.
- dataa  in  DATA_W  multiplicand.
- datab  in  DATA_W  multiplier.
- sload  in  1  load product into accumulator instead of adding; qualified by in_valid.
- approx  in  1  1 = approximate product, 0 = exact.
- adder_out  out  ACC_W  accumulator value.
- out_valid  out  1  adder_out updated by a valid sample on the last enabled edge.
- overflow  out  1  sticky accumulator overflow.

## Operation
- Stage 1 registers p, v1 = in_valid, s1 = sload.
  - Exact product: p = dataa*datab, width 2*DATA_W.
  - Approximate product, APPROX_K>0: low APPROX_K bits of the product forced to 0, then bit APPROX_K-1 forced to 1 (mid-point bias). APPROX_K = 0 gives the exact product.
- Stage 2 updates the accumulator only when v1=1:
  - s1=1: acc = zero-extended p, and overflow clears.
  - s1=0: sum = acc + p, computed ACC_W+1 wide. Carry-out sets overflow; the overflowed result is handled per Configuration.
  - v1=0: acc and overflow hold.
- out_valid is registered v1.
- The approx input is sampled per sample, so exact and approximate samples may be interleaved freely.
- in_valid=0 inserts a bubble. sload and approx are ignored on bubbles.

## Timing
- Reset (aclr=1, asynchronous): every register clears, so adder_out=0, out_valid=0, overflow=0, and all stage-1 registers are 0. Reset asserted mid-pipeline discards in-flight samples.
- Reset deassertion is taken synchronously by the next enabled edge.
- Latency 2 enabled edges:
  - Sample presented before edge N is captured into stage 1 at N.
  - Accumulated at N+1, with adder_out and out_valid=1 visible after N+1.
- Throughput: one sample per enabled cycle.
- clken=0: all state holds, including out_valid and overflow. A sample at the inputs during clken=0 is not captured.
- A sload sample directly following an overflowing sample: the accumulator reloads and overflow clears on the same edge.
- Back-to-back sload samples: each replaces the accumulator in turn.

## Configuration
- MACISH_SAT_EN defined:
  - On carry-out, the accumulator saturates to all-ones (2^ACC_W-1).
  - Later accumulations stay saturated until sload or reset.
  - overflow sets and stays set.
- MACISH_SAT_EN undefined: on carry-out, the accumulator wraps modulo 2^ACC_W and overflow sets sticky.

## Structure
- Package macish_pkg holds:
  - The function computing the approximate product from (product, APPROX_K).
  - The ACC_W derivation, as a localparam helper.
- Sub-module macish_approx_mult holds stage 1: multiplier, truncation/bias logic and stage-1 registers, parameterised by DATA_W and APPROX_K.
- The top level holds the accumulator, the overflow logic and the saturation `ifdef`.

## Test plan
All scenarios use the defaults (DATA_W=8, GUARD_W=4, APPROX_K=4, ACC_W=20).
- Reset, then a=4, b=4, sload=1, approx=0 -> after 2 enabled edges, adder_out=16, out_valid=1, overflow=0.
- a=4, b=4, sload=1, approx=1 -> adder_out=24. Then a=255, b=255, approx=1 accumulate -> adder_out=24+65032=65056.
- sload of 255*255 exact, then 16 more accumulates of 255*255:
  - After the 16th sample (first sload + 15 adds): adder_out=1040400.
  - After the 17th sample, with MACISH_SAT_EN: adder_out=1048575, overflow=1.
  - After the 17th sample, without MACISH_SAT_EN: adder_out=56849, overflow=1.
  - A following sload of 3*3 -> adder_out=9, overflow=0.
- Stream of 5 samples with clken=0 for 3 cycles mid-stream -> adder_out and out_valid frozen during the stall, final sum equal to the unstalled reference, no sample lost or duplicated.
- in_valid=0 bubbles interleaved with samples -> out_valid low exactly 2 edges after each bubble, accumulator unchanged on bubbles.
- aclr pulsed asynchronously between edges with 2 samples in flight -> adder_out=0, out_valid=0 and overflow=0 immediately. After release, a new sload of 7*9 -> adder_out=63.
- Random check over 10000 samples -> exact-mode results match the golden model bit-exactly; approximate-mode per-product error ≤ 2^(APPROX_K-1)=8.

Source files
------------

// File: rtl/macish_pkg.sv
`default_nettype none
// ============================================================================
// Module      : macish_pkg
// Description : Shared helpers for the macish parametrised MAC: accumulator
//               width derivation and approximate-product shaping.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package macish_pkg;

    // Widest product the shaping helper accepts (2*DATA_W must not exceed it)
    localparam int C_PROD_MAX_W = 64;

    // Accumulator width: full product plus guard bits
    function automatic int acc_w(input int data_w, input int guard_w);
        return 2 * data_w + guard_w;
    endfunction

    // Clear the k low bits of a product, then set bit k-1 as a mid-point
    // bias so the truncation error is centred rather than one-sided.
    // k = 0 returns the product untouched.
    function automatic logic [C_PROD_MAX_W-1:0] approx_product(
        input logic [C_PROD_MAX_W-1:0] prod,
        input int                      k
    );
        logic [C_PROD_MAX_W-1:0] mask;
        logic [C_PROD_MAX_W-1:0] res;
        mask = (64'd1 << k) - 64'd1;
        res  = prod & ~mask;
        if (k > 0) begin
            res = res | (64'd1 << (k - 1));
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/macish_approx_mult.sv
`default_nettype none
// ============================================================================
// Module      : macish_approx_mult
// Description : Stage 1 of the macish MAC: unsigned multiply, optional
//               truncate-and-bias shaping, and the stage-1 pipeline registers.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module macish_approx_mult
    import macish_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int APPROX_K = 4
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  i_clken,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    input  logic                  i_sload,
    input  logic                  i_approx,
    output logic [2*DATA_W-1:0]   o_p,
    output logic                  o_v1,
    output logic                  o_s1
);

    localparam int C_P_W = 2 * DATA_W;

    logic [C_P_W-1:0] w_a_ext;
    logic [C_P_W-1:0] w_b_ext;
    logic [C_P_W-1:0] w_prod;
    logic [C_P_W-1:0] w_prod_apx;
    logic [C_P_W-1:0] w_p_sel;

    logic [C_P_W-1:0] r_p;
    logic             r_v1;
    logic             r_s1;

    assign w_a_ext    = {{DATA_W{1'b0}}, i_a};
    assign w_b_ext    = {{DATA_W{1'b0}}, i_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_apx = (C_P_W)'(approx_product(64'(w_prod), APPROX_K));
    assign w_p_sel    = i_approx ? w_prod_apx : w_prod;

    // Capture the shaped product and sample qualifiers; bubbles leave p alone
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_p  <= '0;
            r_v1 <= 1'b0;
            r_s1 <= 1'b0;
        end else if (i_clken) begin
            r_v1 <= i_valid;
            r_s1 <= i_valid & i_sload;
            if (i_valid) begin
                r_p <= w_p_sel;
            end
        end
    end

    assign o_p  = r_p;
    assign o_v1 = r_v1;
    assign o_s1 = r_s1;

endmodule
`default_nettype wire

// File: rtl/macish_mac_p.sv
`default_nettype none
// ============================================================================
// Module      : macish_mac_p
// Description : Two-stage pipelined unsigned multiply-accumulate with per-sample
//               exact/approximate products and a sticky overflow flag.
//               Define MACISH_SAT_EN to saturate the accumulator on overflow;
//               otherwise it wraps modulo 2^ACC_W.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module macish_mac_p
    import macish_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int GUARD_W  = 4,
    parameter int APPROX_K = 4
) (
    input  logic                                  clk,
    input  logic                                  aclr,
    input  logic                                  clken,
    input  logic                                  in_valid,
    input  logic [DATA_W-1:0]                     dataa,
    input  logic [DATA_W-1:0]                     datab,
    input  logic                                  sload,
    input  logic                                  approx,
    output logic [acc_w(DATA_W, GUARD_W)-1:0]     adder_out,
    output logic                                  out_valid,
    output logic                                  overflow
);

    localparam int ACC_W = acc_w(DATA_W, GUARD_W);
    localparam int C_P_W = 2 * DATA_W;

    logic [C_P_W-1:0] w_p;
    logic             w_v1;
    logic             w_s1;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_out_valid;

    macish_approx_mult #(
        .DATA_W   (DATA_W),
        .APPROX_K (APPROX_K)
    ) u_stage1 (
        .clk      (clk),
        .aclr     (aclr),
        .i_clken  (clken),
        .i_valid  (in_valid),
        .i_a      (dataa),
        .i_b      (datab),
        .i_sload  (sload),
        .i_approx (approx),
        .o_p      (w_p),
        .o_v1     (w_v1),
        .o_s1     (w_s1)
    );

    // One extra bit so the carry-out is visible as the overflow condition
    assign w_sum = {1'b0, r_acc} + {{(GUARD_W + 1){1'b0}}, w_p};

    // Next accumulator/overflow: load, add (wrap or saturate), or hold
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (w_v1) begin
            if (w_s1) begin
                w_acc_nxt = {{GUARD_W{1'b0}}, w_p};
                w_ovf_nxt = 1'b0;
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) begin
                    w_ovf_nxt = 1'b1;
`ifdef MACISH_SAT_EN
                    w_acc_nxt = '1;
`endif
                end
            end
        end
    end

    // Stage 2 registers: accumulator, sticky overflow and result strobe
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clken) begin
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_v1;
        end
    end

    assign adder_out = r_acc;
    assign out_valid = r_out_valid;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
